// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type and address-field width helpers for cache_ctrl
package cache_pkg;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, RESPOND} cache_state_t;

    // Byte offset inside a line: word index bits plus byte-in-word bits.
    function automatic int offset_width(input int words_per_line, input int data_width);
        return $clog2(words_per_line) + $clog2(data_width / 8);
    endfunction

    function automatic int set_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int address_width, input int sets,
                                     input int words_per_line, input int data_width);
        return address_width - set_width(sets) - offset_width(words_per_line, data_width);
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: direct-mapped tag/valid/dirty/data storage for cache_ctrl
//   clk, reset_n            : clock, async active-low reset (clears valid/dirty only)
//   set_idx, word_idx       : addressed set and word within the line
//   rd_tag/valid/dirty/data : combinational read of the addressed set/word
//   data_we, wr_data        : write one word of the addressed line
//   tag_we, wr_tag          : install a refilled line (valid=1, dirty=0)
//   dirty_set               : mark the addressed line dirty
module cache_line_store
    import cache_pkg::*;
#(
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 22
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [set_width(SETS)-1:0]        set_idx,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] word_idx,
    output logic [TAG_WIDTH-1:0]              rd_tag,
    output logic                              rd_valid,
    output logic                              rd_dirty,
    output logic [DATA_WIDTH-1:0]             rd_data,
    input  logic                              data_we,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              tag_we,
    input  logic [TAG_WIDTH-1:0]              wr_tag,
    input  logic                              dirty_set
);

    logic [TAG_WIDTH-1:0]  tags [SETS];
    logic [DATA_WIDTH-1:0] data [SETS][WORDS_PER_LINE];
    logic [SETS-1:0]       valid;
    logic [SETS-1:0]       dirty;

    assign rd_tag   = tags[set_idx];
    assign rd_valid = valid[set_idx];
    assign rd_dirty = dirty[set_idx];
    assign rd_data  = data[set_idx][word_idx];

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (tag_we)
            tags[set_idx] <= wr_tag;
        if (data_we)
            data[set_idx][word_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (tag_we) begin
            valid[set_idx] <= 1'b1;
            dirty[set_idx] <= 1'b0;
        end else if (dirty_set)
            dirty[set_idx] <= 1'b1;

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back cache controller with word-serial memory refill
//   clk, reset_n : clock, async active-low reset
//   cpu_*        : single-outstanding CPU request, cpu_ready pulses once with cpu_rdata
//   mem_*        : one word per mem_ack; write-back then refill of a whole line
//   hit_cnt/miss_cnt : saturating statistics counters
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_ready,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [CNT_WIDTH-1:0]     hit_cnt,
    output logic [CNT_WIDTH-1:0]     miss_cnt
);

    localparam int OFFSET_WIDTH = offset_width(WORDS_PER_LINE, DATA_WIDTH);
    localparam int SET_WIDTH    = set_width(SETS);
    localparam int TAG_WIDTH    = tag_width(ADDRESS_WIDTH, SETS, WORDS_PER_LINE, DATA_WIDTH);
    localparam int BYTE_WIDTH   = $clog2(DATA_WIDTH / 8);
    localparam int WORD_WIDTH   = OFFSET_WIDTH - BYTE_WIDTH;

    cache_state_t                      state;
    logic [WORD_WIDTH-1:0]             word_cnt;
    logic                              we_q;
    logic [ADDRESS_WIDTH-1:BYTE_WIDTH] addr_q;
    logic [DATA_WIDTH-1:0]             wdata_q;
    logic                              refilled;
    logic [TAG_WIDTH-1:0]              rd_tag;
    logic                              rd_valid;
    logic                              rd_dirty;
    logic [DATA_WIDTH-1:0]             rd_data;
    logic                              unused_byte;

    // Accesses are word-aligned; byte-select bits carry no information.
    assign unused_byte = ^cpu_addr[BYTE_WIDTH-1:0];

    wire [TAG_WIDTH-1:0]  tag_q  = addr_q[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    wire [SET_WIDTH-1:0]  set_q  = addr_q[OFFSET_WIDTH +: SET_WIDTH];
    wire [WORD_WIDTH-1:0] word_q = addr_q[BYTE_WIDTH +: WORD_WIDTH];
    wire                  hit    = rd_valid && rd_tag == tag_q;
    wire                  last   = &word_cnt;
    wire                  wr_hit = state == COMPARE && hit && we_q;

    // Write-back addresses the victim line (stored tag); refill the requested one.
    assign mem_addr  = {state == WRITEBACK ? rd_tag : tag_q, set_q, word_cnt, {BYTE_WIDTH{1'b0}}};
    assign mem_wdata = rd_data;

    cache_line_store #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .DATA_WIDTH     (DATA_WIDTH),
        .TAG_WIDTH      (TAG_WIDTH)
    ) u_store (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_idx   (set_q),
        .word_idx  (state == COMPARE ? word_q : word_cnt),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_data   (rd_data),
        .data_we   (wr_hit || (state == REFILL && mem_ack)),
        .wr_data   (state == COMPARE ? wdata_q : mem_rdata),
        .tag_we    (state == REFILL && mem_ack && last),
        .wr_tag    (tag_q),
        .dirty_set (wr_hit)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            refilled  <= 1'b0;
        end else
            case (state)
                IDLE:
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr[ADDRESS_WIDTH-1:BYTE_WIDTH];
                        wdata_q <= cpu_wdata;
                        state   <= COMPARE;
                    end
                // refilled marks the re-compare after a refill, which is not counted.
                COMPARE:
                    if (hit) begin
                        if (!refilled && ~&hit_cnt)
                            hit_cnt <= hit_cnt + 1'b1;
                        if (!we_q)
                            cpu_rdata <= rd_data;
                        refilled  <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= RESPOND;
                    end else begin
                        if (!refilled && ~&miss_cnt)
                            miss_cnt <= miss_cnt + 1'b1;
                        mem_req <= 1'b1;
                        mem_we  <= rd_valid && rd_dirty;
                        state   <= rd_valid && rd_dirty ? WRITEBACK : REFILL;
                    end
                // word_cnt wraps to 0 on the last word, ready for the next phase.
                WRITEBACK:
                    if (mem_ack) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last) begin
                            mem_we <= 1'b0;
                            state  <= REFILL;
                        end
                    end
                REFILL:
                    if (mem_ack) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last) begin
                            mem_req  <= 1'b0;
                            refilled <= 1'b1;
                            state    <= COMPARE;
                        end
                    end
                RESPOND: begin
                    cpu_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

endmodule
